// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_pkg
// Description : Shared CPU definitions for the fetch stage: the fetch
//               sequencer state encoding and the jump-field width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_unit_pkg;

    // Width of the absolute jump field carried in a jump instruction.
    localparam int JUMP_FIELD_W = 26;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

endpackage : fetch_pc_unit_pkg
`default_nettype wire

// File: rtl/fetch_pc_unit_adder.sv
`default_nettype none
// ============================================================================
// Module      : adder30Bit
// Description : Ripple-carry adder, sum = a + b + cin modulo 2^WIDTH.
//               The carry out of the top bit is intentionally discarded.
// Ports       : a, b   - addends
//               cin    - carry into bit 0
//               sum    - WIDTH-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module adder30Bit #(
    parameter int WIDTH = 30
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ w_carry[i];
        // The top bit's carry-out has nowhere to go, so it is not built.
        if (i < WIDTH - 1) begin : g_carry
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule : adder30Bit
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Word-addressed program counter and fetch sequencer.
//               Advances sequentially when the instruction memory accepts
//               the fetch and decode is not stalling; redirects to a
//               PC-relative branch or absolute jump target and inserts one
//               bubble cycle (FLUSH) after each redirect.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               stall          - hold sequential advance
//               branch_taken   - redirect to pc_plus1 + branch_offset
//               branch_offset  - two's-complement word offset
//               jump           - redirect to {pc_plus1[top], jump_target}
//               jump_target    - low 26 bits of the jump word address
//               fetch_ready    - memory accepts the current fetch
//               pc             - registered fetch word address
//               pc_plus1       - pc + 1 (combinational)
//               fetch_valid    - pc is a valid request (RUN or HOLD)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int               WIDTH    = 30,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [WIDTH-1:0]        branch_offset,
    input  logic                    jump,
    input  logic [JUMP_FIELD_W-1:0] jump_target,
    input  logic                    fetch_ready,
    output logic [WIDTH-1:0]        pc,
    output logic [WIDTH-1:0]        pc_plus1,
    output logic                    fetch_valid
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;
    logic [WIDTH-1:0] w_branch_pc;
    logic [WIDTH-1:0] w_jump_pc;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic             w_advance;

    // pc + 1 is formed as pc + 0 with carry-in set.
    adder30Bit #(.WIDTH(WIDTH)) u_inc (
        .a   (r_pc),
        .b   (C_ZERO),
        .cin (1'b1),
        .sum (w_pc_plus1)
    );

    // Branch offsets are relative to the instruction after the branch.
    adder30Bit #(.WIDTH(WIDTH)) u_branch (
        .a   (w_pc_plus1),
        .b   (branch_offset),
        .cin (1'b0),
        .sum (w_branch_pc)
    );

    assign w_jump_pc  = {w_pc_plus1[WIDTH-1:JUMP_FIELD_W], jump_target};
    assign w_redirect = jump | branch_taken;
    assign w_target   = jump ? w_jump_pc : w_branch_pc;   // jump wins
    assign w_advance  = fetch_ready & ~stall;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_IDLE: begin
                // Redirects are ignored here; pc is already the reset target.
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = ST_FLUSH;
                end else if (w_advance) begin
                    w_pc_next    = w_pc_plus1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                // A redirect here replaces the target and stays in the bubble.
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = ST_FLUSH;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign pc          = r_pc;
    assign pc_plus1    = w_pc_plus1;
    assign fetch_valid = (r_state == ST_RUN) || (r_state == ST_HOLD);

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam int WIDTH = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              branch_taken;
    logic [WIDTH-1:0]  branch_offset;
    logic              jump;
    logic [25:0]       jump_target;
    logic              fetch_ready;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc_plus1;
    logic              fetch_valid;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.WIDTH(WIDTH), .RESET_PC('0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .fetch_ready   (fetch_ready),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .fetch_valid   (fetch_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pv(input string tag, input logic [31:0] exp_pc, input logic exp_fv);
        check({tag, ".pc"}, {2'b00, pc}, exp_pc);
        check({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; fetch_ready = 1'b1;

        // Reset state
        tick(); tick();
        check_pv("rst", 32'h0, 1'b0);
        check("rst.pc1", {2'b00, pc_plus1}, 32'h1);
        reset = 1'b0;
        check_pv("idle", 32'h0, 1'b0);
        check("idle.pc1", {2'b00, pc_plus1}, 32'h1);

        // Sequential run 0,1,2,3
        tick(); check_pv("run0", 32'd0, 1'b1);
        tick(); check_pv("run1", 32'd1, 1'b1);
        tick(); check_pv("run2", 32'd2, 1'b1);
        tick(); check_pv("run3", 32'd3, 1'b1);
        tick(); tick(); check_pv("run5", 32'd5, 1'b1);

        // Memory not ready for 3 cycles at pc 5
        fetch_ready = 1'b0;
        tick(); check_pv("hold_a", 32'd5, 1'b1);
        tick(); check_pv("hold_b", 32'd5, 1'b1);
        tick(); check_pv("hold_c", 32'd5, 1'b1);
        fetch_ready = 1'b1;
        tick(); check_pv("resume6", 32'd6, 1'b1);
        tick(); tick(); check_pv("run8", 32'd8, 1'b1);

        // Backward branch: 9 + (-4) = 5
        branch_taken = 1'b1; branch_offset = 30'h3FFF_FFFC;
        tick(); check_pv("br_flush", 32'd5, 1'b0);
        branch_taken = 1'b0;
        tick(); check_pv("br_run", 32'd5, 1'b1);
        tick(); check_pv("br_next", 32'd6, 1'b1);

        // Decode stall holds pc
        stall = 1'b1;
        tick(); check_pv("stall", 32'd6, 1'b1);
        stall = 1'b0;
        tick(); check_pv("unstall", 32'd7, 1'b1);

        // Branch to top of address space: 8 + 0x3FFFFFF7 = 0x3FFFFFFF
        branch_taken = 1'b1; branch_offset = 30'h3FFF_FFF7;
        tick(); check_pv("br_top", 32'h3FFF_FFFF, 1'b0);
        check("top.pc1", {2'b00, pc_plus1}, 32'h0);

        // Jump and branch together in FLUSH: jump wins, upper bits from pc_plus1=0
        jump = 1'b1; jump_target = 26'h000_0123; branch_offset = 30'h0000_0010;
        tick(); check_pv("jump_win", 32'h0000_0123, 1'b0);
        jump = 1'b0;

        // Back to top: 0x124 + 0x3FFFFEDB = 0x3FFFFFFF
        branch_offset = 30'h3FFF_FEDB;
        tick(); check_pv("br_top2", 32'h3FFF_FFFF, 1'b0);
        branch_taken = 1'b0;
        tick(); check_pv("top_run", 32'h3FFF_FFFF, 1'b1);
        tick(); check_pv("wrap", 32'h0, 1'b1);
        check("wrap.pc1", {2'b00, pc_plus1}, 32'h1);

        // Jump keeps upper pc_plus1 bits: 1 + 0x3FFFFFEF = 0x3FFFFFF0
        branch_taken = 1'b1; branch_offset = 30'h3FFF_FFEF;
        tick(); check_pv("br_hi", 32'h3FFF_FFF0, 1'b0);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 26'h0AB_CDEF;
        tick(); check_pv("jump_hi", 32'h3CAB_CDEF, 1'b0);
        jump = 1'b0;

        // Reset during FLUSH
        reset = 1'b1;
        tick(); check_pv("rst_flush", 32'h0, 1'b0);
        reset = 1'b0;
        check_pv("rst_flush_idle", 32'h0, 1'b0);
        tick(); check_pv("rst_flush_run", 32'h0, 1'b1);

        // Redirects ignored in IDLE
        tick(); tick(); check_pv("adv2", 32'd2, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        jump = 1'b1; jump_target = 26'h000_0055;
        tick(); check_pv("idle_nojump", 32'h0, 1'b1);
        jump = 1'b0;

        // Reset during HOLD with stall asserted
        tick(); tick(); check_pv("adv_b", 32'd2, 1'b1);
        stall = 1'b1;
        tick(); check_pv("hold_stall", 32'd2, 1'b1);
        reset = 1'b1;
        tick(); check_pv("rst_hold", 32'h0, 1'b0);
        reset = 1'b0;
        check_pv("rst_hold_idle", 32'h0, 1'b0);
        tick(); check_pv("rst_hold_run", 32'h0, 1'b1);

        // Redirect overrides stall and not-ready
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_offset = 30'h0000_0009;
        tick(); check_pv("br_over_stall", 32'd10, 1'b0);
        branch_taken = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_pc_unit
`default_nettype wire
